// File: rtl/rvvi_tx_arbiter.sv
// rvvi_tx_arbiter: frame-atomic round-robin arbiter that shares one
// 32-bit AXI-stream MAC TX port among NUM_SRC frame producers.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   SrcTdata/Tkeep/Tvalid/Tlast  packed per-source AXI-stream inputs
//   SrcTready                    per-source ready (granted bit only)
//   TxTdata/Tkeep/Tvalid/Tlast   AXI-stream output to the MAC
//   TxTready                     ready from the MAC
//   GapCycles                    idle cycles after each frame
//   Grant                        registered one-hot grant
//   Busy                         high while sending or in the gap
//   FrameCnt, GapStallCnt        statistics (RVVI_TXARB_STATS_EN only)
//
// Optional macro: RVVI_TXARB_STATS_EN adds per-source frame counters
// and a gap-stall cycle counter.

module rvvi_tx_arbiter #(
  parameter int NUM_SRC   = 3,
  parameter int GAP_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC*32-1:0]  SrcTdata,
  input  logic [NUM_SRC*4-1:0]   SrcTkeep,
  input  logic [NUM_SRC-1:0]     SrcTvalid,
  input  logic [NUM_SRC-1:0]     SrcTlast,
  output logic [NUM_SRC-1:0]     SrcTready,
  output logic [31:0]            TxTdata,
  output logic [3:0]             TxTkeep,
  output logic                   TxTvalid,
  output logic                   TxTlast,
  input  logic                   TxTready,
  input  logic [GAP_WIDTH-1:0]   GapCycles,
  output logic [NUM_SRC-1:0]     Grant,
  output logic                   Busy
`ifdef RVVI_TXARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]  FrameCnt,
  output logic [31:0]            GapStallCnt
`endif
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e               state_q;
  logic [NUM_SRC-1:0]   grant_q;
  logic [NUM_SRC-1:0]   grant_d;
  logic [PW-1:0]        rr_ptr_q;
  logic [PW-1:0]        rr_ptr_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q;
  logic                 busy_q;

  logic [PW-1:0]        gidx;
  logic [PW-1:0]        win_idx;
  logic                 win_found;
  logic [PW:0]          scan_sum;
  logic [2*NUM_SRC-1:0] req_rot;
  logic                 last_hs;

  assign Grant = grant_q;
  assign Busy  = busy_q;

  // Pass-through mux; everything is forced to 0 while no grant is held.
  always_comb begin
    TxTdata   = '0;
    TxTkeep   = '0;
    TxTvalid  = 1'b0;
    TxTlast   = 1'b0;
    SrcTready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        TxTdata      = SrcTdata[32*i +: 32];
        TxTkeep      = SrcTkeep[4*i +: 4];
        TxTvalid     = SrcTvalid[i];
        TxTlast      = SrcTlast[i];
        SrcTready[i] = TxTready;
      end
    end
  end

  assign last_hs = TxTvalid & TxTready & TxTlast;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  assign rr_ptr_d = (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;

  // Rotate requests so bit k is source (RrPtr + k) mod NUM_SRC.
  assign req_rot = {SrcTvalid, SrcTvalid} >> rr_ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        scan_sum  = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (scan_sum >= (PW+1)'(NUM_SRC)) begin
          scan_sum = scan_sum - (PW+1)'(NUM_SRC);
        end
        win_idx = scan_sum[PW-1:0];
      end
    end
  end

  assign grant_d = NUM_SRC'(1) << win_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q <= grant_d;
            state_q <= SEND;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (last_hs) begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= '0;
            if (GapCycles == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_cnt_q <= GapCycles;
              state_q   <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt_q <= gap_cnt_q - 1'b1;
          if (gap_cnt_q == GAP_WIDTH'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RVVI_TXARB_STATS_EN
  logic [31:0] frame_cnt_q [NUM_SRC];
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  // Stall counter saturates instead of wrapping.
  assign stall_d = (stall_q == '1) ? stall_q : stall_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) frame_cnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (last_hs && grant_q[i]) begin
          frame_cnt_q[i] <= frame_cnt_q[i] + 1'b1;
        end
      end
      if (state_q == GAP && |SrcTvalid) stall_q <= stall_d;
    end
  end

  always_comb begin
    FrameCnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      FrameCnt[32*i +: 32] = frame_cnt_q[i];
    end
  end

  assign GapStallCnt = stall_q;
`endif

endmodule
